leap_retire_queue: RTL
======================

LEAP_RETIRE_QUEUE -- requirements
Module: leap_retire_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered leapt results (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  pipeline clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port miss  input  1  MA-stage load/store is stalled on a data-cache miss.
REQ-005 SHALL have port ma_done  input  1  stalled MA op completes its writeback this cycle.
REQ-006 SHALL have port leap_valid  input  1  EX instruction is leapfrogging the stalled MA op this cycle.
REQ-007 SHALL have port leap_rd  input  5  destination register of leapt instruction.
REQ-008 SHALL have port leap_data  input  32  result (rv32i_word) of leapt instruction.
REQ-009 SHALL have port wb_busy  input  1  normal writeback owns the regfile write port this cycle.
REQ-010 SHALL have port leap_ready  output  1  queue accepts a leap this cycle.
REQ-011 SHALL have port drain_valid, drain_rd, drain_data  output  1/5/32  in-order regfile write from queue head.
REQ-012 SHALL have ports fwd_rs1, fwd_rs2  input  5 each, and fwd1_hit, fwd2_hit  output  1, fwd1_data, fwd2_data  output  32: forwarding lookup (see REQ-030).

Function
REQ-013 SHALL implement states IDLE, CAPTURE, DRAIN.
REQ-014 IDLE->CAPTURE when miss=1; CAPTURE->DRAIN on ma_done=1 with count>0 after this cycle's enqueue; CAPTURE->IDLE on ma_done=1 with count=0 after enqueue.
REQ-015 DRAIN->IDLE in the cycle the last entry pops; if miss=1 at that edge, next state SHALL be CAPTURE instead.
REQ-016 leap_ready SHALL be 1 only in CAPTURE with count<DEPTH (combinational from registered state/count).
REQ-017 Leap accepted when leap_valid & leap_ready; rd!=0 enqueues {rd,data} at tail; rd=0 is accepted and discarded (no entry).
REQ-018 leap_valid while leap_ready=0 SHALL be ignored; no state change.
REQ-019 Leap and ma_done in the same cycle: leap SHALL be enqueued before the transition decision.
REQ-020 drain_valid SHALL be 1 iff state=DRAIN, count>0, wb_busy=0; drain_rd/drain_data SHALL show head entry; pop on that edge.
REQ-021 First possible drain_valid SHALL be the cycle after ma_done; one pop per cycle max; strict FIFO order.
REQ-022 Head/tail pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1; full = count==DEPTH, empty = count==0.
REQ-023 No enqueue in DRAIN or IDLE; no pop in CAPTURE or IDLE.
REQ-024 Duplicate rd entries SHALL both be kept and drained in order (younger overwrites older in regfile).

Reset
REQ-025 rst=0 SHALL asynchronously force state IDLE, head=tail=count=0, clearing all entries' valid status.
REQ-026 During reset: leap_ready=0, drain_valid=0, drain_rd=0, drain_data=0, fwd hits=0, fwd data=0.
REQ-027 Reset asserted mid-CAPTURE or mid-DRAIN SHALL drop all buffered entries; no drain after release.
REQ-028 First edge after rst release SHALL evaluate IDLE transitions normally.

Configuration
REQ-029 Macro LEAP_FWD_EN SHALL gate forwarding logic.
REQ-030 With LEAP_FWD_EN: fwdN_hit=1 when any valid entry has rd==fwd_rsN and fwd_rsN!=0; fwdN_data SHALL be youngest matching entry's data; combinational, all states.
REQ-031 Without LEAP_FWD_EN: fwd ports SHALL exist and be tied to 0; forwarding comparators SHALL not be synthesized.

Structure
REQ-032 rv32i_word, rv32i_reg and the state enum type SHALL live in shared package rv32i_types.
REQ-033 Storage/pointers SHALL be sub-module leap_fifo (DEPTH, 37-bit entries, push/pop/count, entry read-out for forwarding); FSM stays in top.

Verification
REQ-034 miss=1, leaps rd=5/0x11, rd=6/0x22, then ma_done -> next cycles drain (5,0x11),(6,0x22), then IDLE.
REQ-035 Five leaps with DEPTH=4 -> leap_ready=0 after fourth; fifth ignored; exactly four drains.
REQ-036 Leap rd=0 data 0xFFFF_FFFF -> accepted, count unchanged, no drain.
REQ-037 DRAIN with wb_busy=1 for 2 cycles -> drain_valid=0 those cycles, entries preserved, drain resumes after.
REQ-038 LEAP_FWD_EN, entries rd=7/0xA then rd=7/0xB, fwd_rs1=7 -> fwd1_hit=1, fwd1_data=0xB; fwd_rs2=0 -> fwd2_hit=0.
REQ-039 rst=0 mid-DRAIN with 3 entries -> immediate drain_valid=0, count=0; after release miss=0 -> stays IDLE, no drains.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I word/register types, leap queue FSM states and queue entry layout.
package rv32i_types;
    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} lrq_state_e;
    typedef struct packed {
        rv32i_reg  rd;
        rv32i_word data;
    } leap_entry_t;
endpackage

// File: rtl/leap_fifo.sv
// leap_fifo: circular buffer of leapt results (37-bit {rd,data} entries).
// Ports: clk, rst (async active-low), push/push_entry enqueue at tail,
// pop dequeues head, head_entry/head/count expose the head and occupancy,
// entries/valid expose every slot for the forwarding lookup.
module leap_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  leap_entry_t             push_entry,
    input  logic                    pop,
    output leap_entry_t             head_entry,
    output logic [AW-1:0]           head,
    output logic [CW-1:0]           count,
    output leap_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]        valid
);
    logic [AW-1:0] tail;

    assign head_entry = entries[head];

    // push and pop are never issued together by the owner FSM, so the
    // valid-bit updates cannot collide on one slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid   <= '0;
            entries <= '0;
        end else begin
            if (push) begin
                entries[tail] <= push_entry;
                valid[tail]   <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/leap_retire_queue.sv
// leap_retire_queue: buffers results of instructions that leapfrog a stalled
// MA-stage cache miss and retires them to the regfile in order afterwards.
// Ports: clk, rst (async active-low); miss/ma_done from the stalled MA op;
// leap_valid/leap_rd/leap_data with leap_ready handshake; wb_busy blocks
// draining; drain_valid/drain_rd/drain_data regfile write from queue head;
// fwd_rs1/fwd_rs2 lookup returning fwd1/fwd2 hit and data.
// Build option: define LEAP_FWD_EN to enable the forwarding lookup;
// otherwise the forwarding outputs are tied to zero.
module leap_retire_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss,
    input  logic        ma_done,
    input  logic        leap_valid,
    input  logic [4:0]  leap_rd,
    input  logic [31:0] leap_data,
    input  logic        wb_busy,
    output logic        leap_ready,
    output logic        drain_valid,
    output logic [4:0]  drain_rd,
    output logic [31:0] drain_data,
    input  logic [4:0]  fwd_rs1,
    input  logic [4:0]  fwd_rs2,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd1_data,
    output logic [31:0] fwd2_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    lrq_state_e              state, next_state;
    logic [CW-1:0]           count;
    logic [AW-1:0]           head;
    leap_entry_t             head_entry;
    leap_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]        valid;
    logic                    push;

    assign leap_ready  = (state == CAPTURE) && (count != CW'(DEPTH));
    // rd=0 leaps are accepted but never stored: x0 is never written.
    assign push        = leap_valid && leap_ready && (leap_rd != '0);
    assign drain_valid = (state == DRAIN) && (count != '0) && !wb_busy;
    assign drain_rd    = drain_valid ? head_entry.rd : '0;
    assign drain_data  = drain_valid ? head_entry.data : '0;

    leap_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry ({leap_rd, leap_data}),
        .pop        (drain_valid),
        .head_entry (head_entry),
        .head       (head),
        .count      (count),
        .entries    (entries),
        .valid      (valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // The CAPTURE exit looks at the occupancy including this cycle's push.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = miss ? CAPTURE : IDLE;
            CAPTURE: if (ma_done) next_state = (count + CW'(push) != '0) ? DRAIN : IDLE;
            DRAIN:   if (count == '0 || (drain_valid && count == CW'(1)))
                         next_state = miss ? CAPTURE : IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifdef LEAP_FWD_EN
    logic [AW-1:0] idx;

    // Scan from head (oldest) towards tail so the last match is the youngest.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (valid[idx] && entries[idx].rd == fwd_rs1 && fwd_rs1 != '0) begin
                fwd1_hit  = 1'b1;
                fwd1_data = entries[idx].data;
            end
            if (valid[idx] && entries[idx].rd == fwd_rs2 && fwd_rs2 != '0) begin
                fwd2_hit  = 1'b1;
                fwd2_data = entries[idx].data;
            end
        end
    end
`else
    logic unused_fwd;

    assign fwd1_hit   = 1'b0;
    assign fwd2_hit   = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
    assign unused_fwd = ^{fwd_rs1, fwd_rs2, head, valid, entries};
`endif
endmodule
